// File: rtl/wrr_arbiter_if.sv
// wrr_arbiter_if
//   Bundles the request/grant signals between N bus masters and the
//   weighted round-robin arbiter.
//   Signals:
//     req       N      request vector, bit i = requester i
//     weight    N*WW   quantum of requester i in weight[i*WW +: WW]
//     lock      1      owner keeps the grant past its quantum while lock && req[owner]
//     gnt       N      registered one-hot grant, all-zero when idle
//     gnt_id    IW     binary index of the current owner, 0 when idle
//     gnt_valid 1      |gnt
//     gnt_last  1      final granted cycle of the current quantum
//   Modports: master = requester side, slave = arbiter side.
interface wrr_arbiter_if #(
  parameter int N  = 4,
  parameter int WW = 4
);
  localparam int IW = $clog2(N);

  logic [N-1:0]    req;
  logic [N*WW-1:0] weight;
  logic            lock;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_id;
  logic            gnt_valid;
  logic            gnt_last;

  modport master (
    output req, weight, lock,
    input  gnt, gnt_id, gnt_valid, gnt_last
  );

  modport slave (
    input  req, weight, lock,
    output gnt, gnt_id, gnt_valid, gnt_last
  );
endinterface

// File: rtl/wrr_arbiter.sv
// wrr_arbiter
//   Weighted round-robin arbiter for N requesters. A granted requester keeps
//   the grant for up to its weight in cycles (weight 0 acts as 1); lock lets
//   the owner hold the grant indefinitely while it keeps requesting. With all
//   weights 1 and lock low it behaves as a plain rotating one-hot arbiter.
//   Ports:
//     clk   in  clock, all state updates on posedge
//     rst   in  asynchronous active-high reset
//     bus   slave modport of wrr_arbiter_if (req/weight/lock in, grant out)
module wrr_arbiter #(
  parameter int N  = 4,
  parameter int WW = 4
) (
  input  logic          clk,
  input  logic          rst,
  wrr_arbiter_if.slave  bus
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  r_gnt;
  logic [IW-1:0] r_gnt_id;
  logic [WW-1:0] r_credit;
  logic [IW-1:0] r_ptr;

  logic [WW-1:0] w_quantum [N];
  logic          w_valid;
  logic          w_hold;
  logic          w_found;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_ptr_next;

  // Per-requester quantum with the zero-weight case folded to 1.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_quantum
      assign w_quantum[gi] = (bus.weight[gi*WW +: WW] == '0) ? WW'(1)
                                                             : bus.weight[gi*WW +: WW];
    end
  endgenerate

  assign w_valid = |r_gnt;

  // The owner keeps the grant while it still requests and either has
  // credit left beyond this cycle or is locked.
  assign w_hold = w_valid && bus.req[r_gnt_id] && ((r_credit > WW'(1)) || bus.lock);

  // Circular search starting at r_ptr; first set request bit wins.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!w_found && bus.req[idx]) begin
        w_found = 1'b1;
        w_win   = IW'(idx);
      end
    end
  end

  // Winner gets lowest priority in the next search.
  assign w_ptr_next = (w_win == IW'(N-1)) ? '0 : w_win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_credit <= '0;
      r_ptr    <= '0;
    end else if (w_hold) begin
      // Credit floors at 1 so a locked owner stays on its last cycle.
      if (r_credit > WW'(1)) r_credit <= r_credit - 1'b1;
    end else if (w_found) begin
      // Covers the sole-requester regrant too: fresh quantum, no idle bubble.
      r_gnt    <= N'(1) << w_win;
      r_gnt_id <= w_win;
      r_credit <= w_quantum[w_win];
      r_ptr    <= w_ptr_next;
    end else begin
      // Idle: any leftover credit is dropped, search pointer kept.
      r_gnt    <= '0;
      r_gnt_id <= '0;
      r_credit <= '0;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_id    = r_gnt_id;
  assign bus.gnt_valid = w_valid;
  assign bus.gnt_last  = w_valid && (r_credit == WW'(1)) && !bus.lock;
endmodule

// File: tb/tb_wrr_arbiter.sv
// tb_wrr_arbiter
//   Directed bench for wrr_arbiter (N=4, WW=4). Stimulus pushes the expected
//   grant/last for each clock edge into a scoreboard queue; a monitor pops
//   and compares after every edge.
module tb_wrr_arbiter;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic       last;
  } exp_t;

  exp_t sb[$];

  wrr_arbiter_if #(.N(4), .WW(4)) bus ();

  wrr_arbiter #(.N(4), .WW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Monitor: compare every scoreboard entry due at this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        if (e.cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL missed_slot got cycle %0d want cycle %0d", cyc, e.cyc);
        end else begin
          check("gnt", 32'(bus.gnt), 32'(e.gnt));
          check("gnt_id", 32'(bus.gnt_id), 32'(idx_of(e.gnt)));
          check("gnt_valid", 32'(bus.gnt_valid), 32'(|e.gnt));
          check("gnt_last", 32'(bus.gnt_last), 32'(e.last));
          $display("cycle %0d req=%b lock=%b gnt=%b last=%b (want gnt=%b last=%b)",
                   cyc, bus.req, bus.lock, bus.gnt, bus.gnt_last, e.gnt, e.last);
        end
      end
    end
  end

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic [3:0] r, input logic l,
                      input logic [3:0] eg, input logic el);
    exp_t e;
    bus.req  = r;
    bus.lock = l;
    e.cyc  = cyc + 1;
    e.gnt  = eg;
    e.last = el;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Called at a negedge; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    check("rst_gnt_valid", 32'(bus.gnt_valid), 32'd0);
    check("rst_gnt_last", 32'(bus.gnt_last), 32'd0);
    $display("reset at cycle %0d gnt=%b valid=%b", cyc, bus.gnt, bus.gnt_valid);
    bus.req  = 4'b0000;
    bus.lock = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    cyc        = 0;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.req    = 4'b0000;
    bus.lock   = 1'b0;
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
    @(negedge clk);

    // 1: equal weights, plain rotation
    do_reset();
    step(4'b1111, 1'b0, 4'b0001, 1'b1);
    step(4'b1111, 1'b0, 4'b0010, 1'b1);
    step(4'b1111, 1'b0, 4'b0100, 1'b1);
    step(4'b1111, 1'b0, 4'b1000, 1'b1);
    step(4'b1111, 1'b0, 4'b0001, 1'b1);
    step(4'b0000, 1'b0, 4'b0000, 1'b0);

    // 2: weights {4,3,2,1}
    bus.weight = {4'd4, 4'd3, 4'd2, 4'd1};
    do_reset();
    step(4'b1111, 1'b0, 4'b0001, 1'b1);
    step(4'b1111, 1'b0, 4'b0010, 1'b0);
    step(4'b1111, 1'b0, 4'b0010, 1'b1);
    step(4'b1111, 1'b0, 4'b0100, 1'b0);
    step(4'b1111, 1'b0, 4'b0100, 1'b0);
    step(4'b1111, 1'b0, 4'b0100, 1'b1);
    step(4'b1111, 1'b0, 4'b1000, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 1'b1);
    step(4'b1111, 1'b0, 4'b0001, 1'b1);

    // 3: sole requester 2, weight 3, regranted without bubble
    bus.weight = {4'd1, 4'd3, 4'd1, 4'd1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b0, 4'b0100, 1'b0);
      step(4'b0100, 1'b0, 4'b0100, 1'b0);
      step(4'b0100, 1'b0, 4'b0100, 1'b1);
    end

    // 4: weights 4, requester 1 drops on its 2nd granted cycle
    bus.weight = {4'd4, 4'd4, 4'd4, 4'd4};
    do_reset();
    step(4'b1111, 1'b0, 4'b0001, 1'b0);
    step(4'b1111, 1'b0, 4'b0001, 1'b0);
    step(4'b1111, 1'b0, 4'b0001, 1'b0);
    step(4'b1111, 1'b0, 4'b0001, 1'b1);
    step(4'b1111, 1'b0, 4'b0010, 1'b0);
    step(4'b1111, 1'b0, 4'b0010, 1'b0);
    step(4'b1101, 1'b0, 4'b0100, 1'b0);
    step(4'b1101, 1'b0, 4'b0100, 1'b0);
    step(4'b1101, 1'b0, 4'b0100, 1'b0);
    step(4'b1101, 1'b0, 4'b0100, 1'b1);

    // 5: weight0 = 0 behaves as 1, weight1 = 2
    bus.weight = {4'd1, 4'd1, 4'd2, 4'd0};
    do_reset();
    step(4'b0011, 1'b0, 4'b0001, 1'b1);
    step(4'b0011, 1'b0, 4'b0010, 1'b0);
    step(4'b0011, 1'b0, 4'b0010, 1'b1);
    step(4'b0011, 1'b0, 4'b0001, 1'b1);
    step(4'b0011, 1'b0, 4'b0010, 1'b0);

    // 6: lock holds owner 2, release hands over to 3, reset mid-hold
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
    do_reset();
    step(4'b1111, 1'b0, 4'b0001, 1'b1);
    step(4'b1111, 1'b0, 4'b0010, 1'b1);
    step(4'b1111, 1'b0, 4'b0100, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 4'b0100, 1'b0);
    step(4'b1111, 1'b0, 4'b1000, 1'b1);
    step(4'b1111, 1'b1, 4'b1000, 1'b0);
    step(4'b1111, 1'b1, 4'b1000, 1'b0);
    do_reset();
    step(4'b1111, 1'b0, 4'b0001, 1'b1);
    step(4'b1111, 1'b0, 4'b0010, 1'b1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL undrained got nothing want gnt=%b at cycle %0d", e.gnt, e.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
